// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg
// Shared definitions for the instruction-fetch front end: the fetch state
// encoding, instruction width, PC step size and the default reset PC.
// No ports; imported by pc_fetch_ctrl, pc_next_sel and pc_fetch_ctrl_if.

package pc_fetch_ctrl_pkg;

    // S_REQ  : request on the memory bus, waiting for gnt
    // S_WAIT : one request outstanding, waiting for rvalid
    // S_HOLD : instruction presented to decode, waiting for if_ready
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if
// Bundles the three handshakes around the fetch stage:
//   imem_*     : req/gnt/rvalid fetch channel to instruction memory
//   if_*       : valid/ready channel to the decode stage
//   redirect_* : branch/jump redirect from later pipeline stages
// modport master : the fetch controller's view
// modport slave  : the surrounding pipeline/memory view

interface pc_fetch_ctrl_if #(
    parameter int ADDR_W = 32
);
    import pc_fetch_ctrl_pkg::*;

    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    logic               if_valid;
    logic               if_ready;
    logic [ADDR_W-1:0]  if_pc;
    logic [ADDR_W-1:0]  if_pc4;
    logic [INSTR_W-1:0] if_instr;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output if_valid, if_pc, if_pc4, if_instr,
        input  if_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  if_valid, if_pc, if_pc4, if_instr,
        output if_ready
    );

endinterface

// File: rtl/pc_fetch_ctrl_next_sel.sv
// pc_next_sel
// Combinational next-PC selection for the fetch stage.
// Ports:
//   state          in  current fetch state
//   gnt            in  memory accepted the request this cycle
//   redirect_valid in  branch/jump taken this cycle
//   redirect_pc    in  redirect target (low two bits ignored)
//   pc             in  current PC register
//   pc_next        out value the PC register takes at the next edge

module pc_next_sel
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  fetch_state_t      state,
    input  logic              gnt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next
);

    logic [ADDR_W-1:0] redirect_aligned;

    // Instructions are word aligned, so the low two target bits are masked off.
    assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

    // A redirect always wins, even over a grant in the same cycle; otherwise
    // the PC only advances when memory accepts the request. The add wraps
    // naturally at 2^ADDR_W.
    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = redirect_aligned;
        end else if (state == S_REQ && gnt) begin
            pc_next = pc + ADDR_W'(PC_STEP);
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
// Instruction-fetch front end: owns the PC, issues one outstanding fetch at a
// time to instruction memory and presents each fetched word to decode. Branch
// and jump redirects replace the PC and discard any fetch they make stale.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  pc_fetch_ctrl_if.master: imem req/gnt/rvalid channel, decode
//        valid/ready channel and redirect inputs

module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    pc_fetch_ctrl_if.master       bus
);

    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_next;
    logic [ADDR_W-1:0]  fetch_pc;
    logic               kill;
    logic               in_req;
    logic               if_valid_q;
    logic [ADDR_W-1:0]  if_pc_q;
    logic [ADDR_W-1:0]  if_pc4_q;
    logic [INSTR_W-1:0] if_instr_q;

    pc_next_sel #(
        .ADDR_W (ADDR_W)
    ) u_next_sel (
        .state          (state),
        .gnt            (bus.imem_gnt),
        .redirect_valid (bus.redirect_valid),
        .redirect_pc    (bus.redirect_pc),
        .pc             (pc),
        .pc_next        (pc_next)
    );

    // The reset state is S_REQ, so the request is masked while rst is high;
    // this keeps imem_req low during reset and lets it rise in the very first
    // cycle after rst falls without spending a cycle in an idle state.
    assign in_req        = (state == S_REQ) && !rst;
    assign bus.imem_req  = in_req;
    assign bus.imem_addr = in_req ? pc : '0;

    assign bus.if_valid  = if_valid_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_pc4    = if_pc4_q;
    assign bus.if_instr  = if_instr_q;

    // Fetch FSM. kill marks the single outstanding fetch as stale after a
    // redirect; its response is swallowed when it arrives. rvalid outside
    // S_WAIT is ignored. The decode-side registers only change on capture,
    // so they hold steady under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            fetch_pc   <= '0;
            kill       <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_pc4_q   <= '0;
            if_instr_q <= '0;
        end else begin
            pc <= pc_next;
            case (state)
                S_REQ: begin
                    if (bus.imem_gnt) begin
                        fetch_pc <= pc;
                        kill     <= bus.redirect_valid;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (kill || bus.redirect_valid) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            if_instr_q <= bus.imem_rdata;
                            if_pc_q    <= fetch_pc;
                            if_pc4_q   <= fetch_pc + ADDR_W'(PC_STEP);
                            if_valid_q <= 1'b1;
                            state      <= S_HOLD;
                        end
                    end else if (bus.redirect_valid) begin
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.redirect_valid || bus.if_ready) begin
                        if_valid_q <= 1'b0;
                        state      <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl
// Randomised bench for pc_fetch_ctrl. dut0 (RESET_PC=0) is driven by a
// memory/decode/redirect stimulus generator and checked against a
// transaction-level model: the architectural fetch address stream, the single
// outstanding fetch and the word currently owed to decode. dut1
// (RESET_PC=0xFFFF_FFFC) is driven directly to exercise PC wrap and a reset
// asserted while a fetch is outstanding.

module tb_pc_fetch_ctrl;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    logic rst1;

    always #5 clk = ~clk;

    pc_fetch_ctrl_if #(.ADDR_W(32)) bus0 ();
    pc_fetch_ctrl_if #(.ADDR_W(32)) bus1 ();

    pc_fetch_ctrl #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.master)
    );

    pc_fetch_ctrl #(
        .ADDR_W   (32),
        .RESET_PC (32'hFFFF_FFFC)
    ) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1.master)
    );

    int checks = 0;
    int errors = 0;

    // Model state: next address the fetch stream must request, the one fetch
    // memory owes us, and the words that decode is owed (at most one).
    logic [31:0] exp_pc;
    bit          pending;
    bit          pend_stale;
    logic [31:0] pend_addr;
    int          wait_cnt;
    item_t       live_q[$];
    int          cyc;
    int          last_accept;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)",
                     tag, actual, expected, cyc);
        end
    endtask

    // One call runs n cycles on dut0 with the given grant, ready and redirect
    // probabilities, maximum response latency and throughput mode. Each cycle
    // samples outputs at the negedge, checks them against the model, drives
    // new inputs and advances the model to reflect the coming posedge.
    task automatic applyStimulus(input int n, input int gnt_pct, input int ready_pct,
                                 input int redir_pct, input int max_wait,
                                 input bit throughput);
        last_accept = -1;
        for (int i = 0; i < n; i++) begin
            logic        req, vld, g, rv, rd, redir;
            logic [31:0] addr, ipc, ipc4, instr, rdata, rpc;
            bit          grant, accept, resp;

            req   = bus0.imem_req;
            addr  = bus0.imem_addr;
            vld   = bus0.if_valid;
            ipc   = bus0.if_pc;
            ipc4  = bus0.if_pc4;
            instr = bus0.if_instr;

            checkOutput("imem_req", {31'd0, req}, {31'd0, !pending && live_q.size() == 0});
            if (req) checkOutput("imem_addr", addr, exp_pc);
            checkOutput("if_valid", {31'd0, vld}, {31'd0, live_q.size() != 0});
            if (vld && live_q.size() != 0) begin
                checkOutput("if_pc", ipc, live_q[0].addr);
                checkOutput("if_pc4", ipc4, live_q[0].addr + 32'd4);
                checkOutput("if_instr", instr, live_q[0].data);
            end

            g     = ($urandom_range(99) < gnt_pct);
            rd    = ($urandom_range(99) < ready_pct);
            redir = ($urandom_range(99) < redir_pct);
            rdata = $urandom;
            case ($urandom_range(3))
                0:       rpc = $urandom;
                1:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
                2:       rpc = 32'($urandom_range(255));
                default: rpc = 32'h0000_0100 + 32'($urandom_range(3));
            endcase
            if (pending) begin
                rv = (wait_cnt == 0);
                if (wait_cnt > 0) wait_cnt--;
            end else begin
                rv = !throughput && ($urandom_range(15) == 0);
            end

            bus0.imem_gnt       = g;
            bus0.imem_rvalid    = rv;
            bus0.imem_rdata     = rdata;
            bus0.if_ready       = rd;
            bus0.redirect_valid = redir;
            bus0.redirect_pc    = rpc;

            grant  = req && g;
            accept = vld && rd;
            resp   = pending && rv;

            if (throughput && accept) begin
                if (last_accept >= 0) checkOutput("throughput", 32'(cyc - last_accept), 32'd3);
                last_accept = cyc;
            end

            if (redir) live_q.delete();
            else if (accept && live_q.size() != 0) void'(live_q.pop_front());

            if (resp) begin
                if (!pend_stale && !redir) live_q.push_back(item_t'{pend_addr, rdata});
                pending = 1'b0;
            end else if (pending && redir) begin
                pend_stale = 1'b1;
            end

            if (grant) begin
                pending    = 1'b1;
                pend_addr  = exp_pc;
                pend_stale = redir;
                wait_cnt   = $urandom_range(max_wait);
            end

            if (redir) exp_pc = rpc & ~32'd3;
            else if (grant) exp_pc = exp_pc + 32'd4;

            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst  = 1'b1;
        rst1 = 1'b1;
        bus0.imem_gnt = 1'b0; bus0.imem_rvalid = 1'b0; bus0.imem_rdata = '0;
        bus0.if_ready = 1'b0; bus0.redirect_valid = 1'b0; bus0.redirect_pc = '0;
        bus1.imem_gnt = 1'b0; bus1.imem_rvalid = 1'b0; bus1.imem_rdata = '0;
        bus1.if_ready = 1'b0; bus1.redirect_valid = 1'b0; bus1.redirect_pc = '0;
        exp_pc = 32'h0; pending = 1'b0; pend_stale = 1'b0; pend_addr = '0;
        wait_cnt = 0; cyc = 0; last_accept = -1;

        repeat (2) @(negedge clk);
        checkOutput("rst_imem_req", {31'd0, bus0.imem_req}, 32'd0);
        checkOutput("rst_imem_addr", bus0.imem_addr, 32'd0);
        checkOutput("rst_if_valid", {31'd0, bus0.if_valid}, 32'd0);
        checkOutput("rst_if_pc", bus0.if_pc, 32'd0);
        checkOutput("rst_if_pc4", bus0.if_pc4, 32'd0);
        checkOutput("rst_if_instr", bus0.if_instr, 32'd0);
        rst = 1'b0;
        #1;

        applyStimulus(30, 100, 100, 0, 0, 1'b1);
        applyStimulus(1500, 60, 60, 12, 3, 1'b0);
        applyStimulus(300, 15, 90, 0, 2, 1'b0);
        applyStimulus(300, 90, 10, 0, 1, 1'b0);
        applyStimulus(600, 70, 50, 35, 3, 1'b0);
        applyStimulus(400, 60, 60, 12, 3, 1'b0);
        applyStimulus(30, 100, 100, 0, 0, 1'b1);

        // dut1: reset PC at the top of the address space, then reset mid-fetch
        @(negedge clk);
        checkOutput("d1_rst_req", {31'd0, bus1.imem_req}, 32'd0);
        checkOutput("d1_rst_valid", {31'd0, bus1.if_valid}, 32'd0);
        rst1 = 1'b0;
        #1;
        checkOutput("d1_first_req", {31'd0, bus1.imem_req}, 32'd1);
        checkOutput("d1_first_addr", bus1.imem_addr, 32'hFFFF_FFFC);
        bus1.imem_gnt = 1'b1;
        @(negedge clk);
        bus1.imem_gnt = 1'b0;
        checkOutput("d1_wait_req", {31'd0, bus1.imem_req}, 32'd0);
        bus1.imem_rvalid = 1'b1;
        bus1.imem_rdata  = 32'h1234_5678;
        @(negedge clk);
        bus1.imem_rvalid = 1'b0;
        checkOutput("d1_if_valid", {31'd0, bus1.if_valid}, 32'd1);
        checkOutput("d1_if_pc", bus1.if_pc, 32'hFFFF_FFFC);
        checkOutput("d1_if_pc4", bus1.if_pc4, 32'h0000_0000);
        checkOutput("d1_if_instr", bus1.if_instr, 32'h1234_5678);
        bus1.if_ready = 1'b1;
        @(negedge clk);
        bus1.if_ready = 1'b0;
        checkOutput("d1_second_req", {31'd0, bus1.imem_req}, 32'd1);
        checkOutput("d1_second_addr", bus1.imem_addr, 32'h0000_0000);
        bus1.imem_gnt = 1'b1;
        @(negedge clk);
        bus1.imem_gnt = 1'b0;
        checkOutput("d1_wait2_req", {31'd0, bus1.imem_req}, 32'd0);
        rst1 = 1'b1;
        #1;
        checkOutput("d1_midrst_req", {31'd0, bus1.imem_req}, 32'd0);
        checkOutput("d1_midrst_valid", {31'd0, bus1.if_valid}, 32'd0);
        checkOutput("d1_midrst_pc", bus1.if_pc, 32'd0);
        checkOutput("d1_midrst_pc4", bus1.if_pc4, 32'd0);
        checkOutput("d1_midrst_instr", bus1.if_instr, 32'd0);
        @(negedge clk);
        checkOutput("d1_inrst_req", {31'd0, bus1.imem_req}, 32'd0);
        rst1 = 1'b0;
        #1;
        checkOutput("d1_rel_req", {31'd0, bus1.imem_req}, 32'd1);
        checkOutput("d1_rel_addr", bus1.imem_addr, 32'hFFFF_FFFC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
